i2c_pio_in: RTL



---
 rtl/i2c_pio_pkg.sv | 15 +
 rtl/i2c_pio_sync_bit.sv | 60 ++++++
 rtl/i2c_pio_in.sv | 116 +++++++++++
 3 files changed

// File: rtl/i2c_pio_pkg.sv
// Shared constants for the I2C bit-bang PIO input port: register map,
// edge-select encodings and the Avalon data-bus width.
package i2c_pio_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/i2c_pio_sync_bit.sv
// Single-bit input conditioning: SYNC_STAGES-deep synchronizer followed by an
// optional stable-count glitch filter (macro I2C_PIO_IN_GLITCH_FILTER_EN).
// Without the macro the conditioned value is the synchronizer output.
module i2c_pio_sync_bit #(
  parameter int unsigned SYNC_STAGES   = 2
`ifdef I2C_PIO_IN_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILTER_CYCLES = 8
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;

  // Metastability synchronizer chain, pin enters at bit 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef I2C_PIO_IN_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Accept a new level only after it has persisted FILTER_CYCLES cycles
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (raw != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) filt_d = raw;
      else                                    cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = raw;
`endif

endmodule

// File: rtl/i2c_pio_in.sv
// Avalon-MM input PIO for the I2C bit-bang lines: synchronized pin readback,
// sticky edge capture with write-1-to-clear, and a maskable level interrupt.
// Optional glitch filter enabled by defining I2C_PIO_IN_GLITCH_FILTER_EN.
module i2c_pio_in
  import i2c_pio_pkg::*;
#(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned EDGE_TYPE     = 2,
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  input  logic [WIDTH-1:0]     in_port,
  output logic [31:0]          readdata,
  output logic                 irq
);

`ifdef I2C_PIO_IN_GLITCH_FILTER_EN
  localparam int unsigned FILT_LAT = FILTER_CYCLES;
`else
  localparam int unsigned FILT_LAT = FILTER_CYCLES * 0;
`endif
  // Arm window covers the pipeline so pins high through reset raise nothing
  localparam int unsigned ARM_MAX = SYNC_STAGES + 1 + FILT_LAT;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] evt;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             armed;
  logic             wr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  // Per-bit synchronizer and optional filter
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    i2c_pio_sync_bit #(
      .SYNC_STAGES  (SYNC_STAGES)
`ifdef I2C_PIO_IN_GLITCH_FILTER_EN
      ,
      .FILTER_CYCLES(FILTER_CYCLES)
`endif
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .filt   (val[i])
    );
  end

  assign armed = (arm_q == ARM_W'(ARM_MAX));
  assign wr    = chipselect && !write_n;

  // Next-state logic for edge capture, mask, arm counter, readback and irq
  always_comb begin
    evt     = '0;
    arm_d   = arm_q;
    mask_d  = mask_q;
    edge_d  = edge_q;
    rdata_d = '0;
    irq_d   = |(edge_q & mask_q);

    if (EDGE_TYPE == EDGE_RISE)      evt = val & ~prev_q;
    else if (EDGE_TYPE == EDGE_FALL) evt = ~val & prev_q;
    else                             evt = val ^ prev_q;
    if (!armed) begin
      evt   = '0;
      arm_d = arm_q + ARM_W'(1);
    end

    if (wr && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr && address == ADDR_EDGE) edge_d = edge_q & ~writedata[WIDTH-1:0];
    edge_d = edge_d | evt;

    case (address)
      ADDR_DATA: rdata_d = MAX_WIDTH'(val);
      ADDR_MASK: rdata_d = MAX_WIDTH'(mask_q);
      ADDR_EDGE: rdata_d = MAX_WIDTH'(edge_q);
      default:   rdata_d = '0;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      arm_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_q  <= val;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      arm_q   <= arm_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule
